// File: rtl/class_argmax_collector_if.sv
// ---------------------------------------------------------------------------
// class_argmax_collector_if
// Bundles the per-lane score inputs and the result handshake of the
// class_argmax_collector.
//   valid_in  [N_MATS]        per-lane strobe qualifying sum_in[i]
//   sum_in    [N_MATS] x DW   signed per-lane scores
//   in_ready                  collector accepts lane strobes
//   out_valid / out_ready     result handshake
//   class_idx                 index of the winning lane
//   max_score                 score of the winning lane
//   drop_err                  sticky flag: a strobe arrived while not ready
// master: producer/consumer side (drives lanes and out_ready)
// slave : collector side
// ---------------------------------------------------------------------------
interface class_argmax_collector_if #(
    parameter int N_MATS     = 10,
    parameter int DATA_WIDTH = 16
);
    localparam int IDX_W = $clog2(N_MATS);

    logic [N_MATS-1:0]            valid_in;
    logic signed [DATA_WIDTH-1:0] sum_in [N_MATS];
    logic                         in_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic [IDX_W-1:0]             class_idx;
    logic signed [DATA_WIDTH-1:0] max_score;
    logic                         drop_err;

    modport master (
        output valid_in,
        output sum_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  class_idx,
        input  max_score,
        input  drop_err
    );

    modport slave (
        input  valid_in,
        input  sum_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output class_idx,
        output max_score,
        output drop_err
    );
endinterface

// File: rtl/class_argmax_collector.sv
// ---------------------------------------------------------------------------
// class_argmax_collector
// Collects one signed score per lane (lanes may arrive in different cycles,
// last write wins), then walks the lanes one per cycle to find the maximum
// (strictly-greater compare, so ties keep the lowest index) and presents
// {class_idx, max_score} over a valid/ready handshake.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  class_argmax_collector_if.slave (lane inputs, result handshake,
//        in_ready, sticky drop_err)
// ---------------------------------------------------------------------------
module class_argmax_collector #(
    parameter int N_MATS     = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    class_argmax_collector_if.slave bus
);
    localparam int               IDX_W    = $clog2(N_MATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MATS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [N_MATS-1:0]            r_flags;
    logic [N_MATS-1:0]            w_accept;
    logic [N_MATS-1:0]            w_flags_nxt;
    logic                         w_all_set;
    logic                         w_handshake;
    logic                         w_last_lane;
    logic                         w_drop;

    logic signed [DATA_WIDTH-1:0] r_score [N_MATS];
    logic [IDX_W-1:0]             r_cnt;

    logic signed [DATA_WIDTH-1:0] r_best_val;
    logic [IDX_W-1:0]             r_best_idx;
    logic signed [DATA_WIDTH-1:0] w_lane_val;
    logic signed [DATA_WIDTH-1:0] w_cand_val;
    logic [IDX_W-1:0]             w_cand_idx;

    logic                         r_in_ready;
    logic                         r_out_valid;
    logic                         r_drop_err;
    logic [IDX_W-1:0]             r_class_idx;
    logic signed [DATA_WIDTH-1:0] r_max_score;

    // Lane acceptance, collection-complete detection and handshake decode.
    always_comb begin
        w_accept    = bus.valid_in & {N_MATS{r_in_ready}};
        // Lanes captured on this same edge count towards completion.
        w_flags_nxt = r_flags | w_accept;
        w_all_set   = &w_flags_nxt;
        w_handshake = r_out_valid & bus.out_ready;
        w_last_lane = (r_cnt == LAST_IDX);
        w_drop      = (|bus.valid_in) & ~r_in_ready;
    end

    // Candidate best after processing lane r_cnt during SCAN.
    always_comb begin
        w_lane_val = r_score[r_cnt];
        if (r_cnt == IDX_ZERO) begin
            // First lane seeds the running best unconditionally.
            w_cand_val = w_lane_val;
            w_cand_idx = IDX_ZERO;
        end else if (w_lane_val > r_best_val) begin
            w_cand_val = w_lane_val;
            w_cand_idx = r_cnt;
        end else begin
            w_cand_val = r_best_val;
            w_cand_idx = r_best_idx;
        end
    end

    // Next-state logic of the collect/scan/done sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: begin
                if (w_all_set) begin
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_SCAN: begin
                if (w_last_lane) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_DONE: begin
                if (w_handshake) begin
                    w_state_nxt = ST_COLLECT;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it is
    // already low in the first SCAN cycle and high right after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_COLLECT);
        end
    end

    // Lane flags: set on capture, cleared when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= {N_MATS{1'b0}};
        end else if (r_state == ST_COLLECT) begin
            r_flags <= w_flags_nxt;
        end else if ((r_state == ST_DONE) && w_handshake) begin
            r_flags <= {N_MATS{1'b0}};
        end else begin
            r_flags <= r_flags;
        end
    end

    // Score registers: last accepted strobe per lane wins; never cleared
    // by the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MATS; i++) begin
                r_score[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_MATS; i++) begin
                if (w_accept[i]) begin
                    r_score[i] <= bus.sum_in[i];
                end else begin
                    r_score[i] <= r_score[i];
                end
            end
        end
    end

    // Scan counter and running best.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= IDX_ZERO;
            r_best_val <= {DATA_WIDTH{1'b0}};
            r_best_idx <= IDX_ZERO;
        end else if ((r_state == ST_COLLECT) && w_all_set) begin
            r_cnt      <= IDX_ZERO;
            r_best_val <= r_best_val;
            r_best_idx <= r_best_idx;
        end else if (r_state == ST_SCAN) begin
            r_cnt      <= w_last_lane ? IDX_ZERO : (r_cnt + IDX_ONE);
            r_best_val <= w_cand_val;
            r_best_idx <= w_cand_idx;
        end else begin
            r_cnt      <= r_cnt;
            r_best_val <= r_best_val;
            r_best_idx <= r_best_idx;
        end
    end

    // Result registers: loaded with the final candidate on the last scan
    // edge and held until the handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_class_idx <= IDX_ZERO;
            r_max_score <= {DATA_WIDTH{1'b0}};
        end else if ((r_state == ST_SCAN) && w_last_lane) begin
            r_out_valid <= 1'b1;
            r_class_idx <= w_cand_idx;
            r_max_score <= w_cand_val;
        end else if ((r_state == ST_DONE) && w_handshake) begin
            r_out_valid <= 1'b0;
            r_class_idx <= r_class_idx;
            r_max_score <= r_max_score;
        end else begin
            r_out_valid <= r_out_valid;
            r_class_idx <= r_class_idx;
            r_max_score <= r_max_score;
        end
    end

    // Sticky drop error: any strobe while not ready; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if (w_drop) begin
            r_drop_err <= 1'b1;
        end else begin
            r_drop_err <= r_drop_err;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.class_idx = r_class_idx;
    assign bus.max_score = r_max_score;
    assign bus.drop_err  = r_drop_err;

endmodule

// File: tb/tb_class_argmax_collector.sv
// ---------------------------------------------------------------------------
// tb_class_argmax_collector
// Directed scenarios plus randomized rounds checked against a reference
// model that keeps the last written score per lane and picks the lowest
// index holding the maximum signed value.
// ---------------------------------------------------------------------------
module tb_class_argmax_collector;
    localparam int N  = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    class_argmax_collector_if #(.N_MATS(N), .DATA_WIDTH(DW)) bus ();

    class_argmax_collector #(.N_MATS(N), .DATA_WIDTH(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic signed [DW-1:0] m_score [N];
    logic [N-1:0]         m_flag;
    logic signed [DW-1:0] vals [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Maximum signed score currently held by the model.
    function automatic logic signed [DW-1:0] ref_max();
        logic signed [DW-1:0] mx;
        mx = m_score[0];
        for (int i = 1; i < N; i++) begin
            if (m_score[i] > mx) mx = m_score[i];
        end
        return mx;
    endfunction

    // Lowest lane index holding the maximum.
    function automatic int ref_idx();
        logic signed [DW-1:0] mx;
        mx = ref_max();
        for (int i = 0; i < N; i++) begin
            if (m_score[i] == mx) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of lane strobes with the values in vals[].
    task automatic drive(input logic [N-1:0] mask);
        bus.valid_in = mask;
        for (int i = 0; i < N; i++) bus.sum_in[i] = vals[i];
        @(posedge clk); #1;
        bus.valid_in = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                m_score[i] = vals[i];
                m_flag[i]  = 1'b1;
            end
        end
        if (!(&m_flag)) begin
            check_eq("collect_in_ready", 32'(bus.in_ready), 32'd1);
            check_eq("collect_no_valid", 32'(bus.out_valid), 32'd0);
        end
    endtask

    // Wait for the result after the final capture, check it, optionally hold
    // backpressure (with dropped strobes), then complete the handshake.
    task automatic finish_round(input string tag, input int hold, input bit strobe_hold,
                                input bit strobe_hs);
        int lat;
        lat = -1;
        for (int c = 1; c <= 3 * N; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(N));
        check_eq({tag, "_idx"}, 32'(bus.class_idx), 32'(ref_idx()));
        check_eq({tag, "_max"}, 32'(bus.max_score), 32'(ref_max()));
        check_eq({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (strobe_hold) begin
                for (int i = 0; i < N; i++) bus.sum_in[i] = DW'($urandom);
                bus.valid_in = N'($urandom) | N'(1);
            end
            @(posedge clk); #1;
            bus.valid_in = '0;
            check_eq({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, "_hold_idx"}, 32'(bus.class_idx), 32'(ref_idx()));
            check_eq({tag, "_hold_max"}, 32'(bus.max_score), 32'(ref_max()));
            check_eq({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        if (strobe_hold) begin
            check_eq({tag, "_drop_err"}, 32'(bus.drop_err), 32'd1);
        end
        bus.out_ready = 1'b1;
        if (strobe_hs) begin
            for (int i = 0; i < N; i++) bus.sum_in[i] = 16'sh7FFF;
            bus.valid_in = '1;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.valid_in  = '0;
        m_flag = '0;
        check_eq({tag, "_ack_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_ack_in_ready"}, 32'(bus.in_ready), 32'd1);
        if (strobe_hs) begin
            // A strobe on the handshake edge must not start a collection.
            @(posedge clk); #1;
            check_eq({tag, "_hs_drop_ready"}, 32'(bus.in_ready), 32'd1);
            check_eq({tag, "_hs_drop_err"}, 32'(bus.drop_err), 32'd1);
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        logic [N-1:0] lo_mask;
        logic signed [DW-1:0] pool [4];

        pool[0] = 16'sh8000; pool[1] = 16'shFFFF; pool[2] = 16'sh0000; pool[3] = 16'sh7FFF;
        lo_mask = '0;
        for (int i = 0; i < N - 1; i++) lo_mask[i] = 1'b1;

        rst = 1'b1;
        bus.valid_in  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.sum_in[i] = '0;
            m_score[i]    = '0;
            vals[i]       = '0;
        end
        m_flag = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_class_idx", 32'(bus.class_idx), 32'd0);
        check_eq("rst_max_score", 32'(bus.max_score), 32'd0);
        check_eq("rst_drop_err", 32'(bus.drop_err), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // All lanes in one cycle, lane 7 wins.
        for (int i = 0; i < N; i++) vals[i] = DW'(i * 16);
        vals[7] = 16'sh0300;
        drive('1);
        finish_round("same_cycle", 0, 1'b0, 1'b0);
        check_eq("same_cycle_const_idx", 32'(ref_idx()), 32'd7);

        // Staggered lanes with an overwrite of lane 2.
        for (int i = 0; i < N; i++) vals[i] = DW'(i * 16);
        drive(N'(10'h01F));
        drive('0);
        vals[2] = 16'sh7FFF;
        drive(N'(10'h004));
        drive(N'(10'h3E0));
        finish_round("staggered", 0, 1'b0, 1'b0);

        // Negative scores with a tie: lowest index wins; backpressure with
        // dropped strobes during DONE.
        for (int i = 0; i < N; i++) vals[i] = 16'sh8000;
        vals[3] = 16'shFFF0;
        vals[8] = 16'shFFF0;
        drive('1);
        finish_round("neg_tie", 20, 1'b1, 1'b0);

        // All equal, staggered so a stale flag would end collection early;
        // also strobe on the handshake edge.
        for (int i = 0; i < N; i++) vals[i] = 16'sh1234;
        drive(lo_mask);
        drive('0);
        drive('0);
        drive(~lo_mask);
        finish_round("all_equal", 2, 1'b0, 1'b1);

        // Reset during SCAN at lane 4.
        for (int i = 0; i < N; i++) vals[i] = DW'($urandom);
        drive('1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midscan_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midscan_rst_idx", 32'(bus.class_idx), 32'd0);
        check_eq("midscan_rst_max", 32'(bus.max_score), 32'd0);
        check_eq("midscan_rst_drop", 32'(bus.drop_err), 32'd0);
        check_eq("midscan_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        m_flag = '0;
        for (int i = 0; i < N; i++) m_score[i] = '0;
        @(posedge clk); #1;
        check_eq("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < N; i++) vals[i] = DW'($urandom);
        drive(lo_mask);
        drive('0);
        drive(~lo_mask);
        finish_round("post_rst", 0, 1'b0, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 6; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (r[0]) vals[i] = pool[$urandom_range(0, 3)];
                    else      vals[i] = DW'($urandom);
                end
                mask = N'($urandom);
                if (c == 5) mask = mask | ~m_flag;
                drive(mask);
                if (&m_flag) break;
            end
            finish_round("random", int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/class_argmax_collector.md
Name: class_argmax_collector

Overview:
- Downstream consumer of the parallel per-matrix reduction array (N_MATS lanes, each with its own valid strobe).
- Collects one score per lane; lanes may arrive in different cycles. Then runs a sequential compare to find the winning class.
- Presents {class index, max score} to the classification output stage over a valid/ready handshake.

Parameters:
- N_MATS, 10, number of lanes/classes; legal range >= 2.
- DATA_WIDTH, 16, score width; scores are signed two's complement.
- IDX_W (localparam), $clog2(N_MATS), width of the class index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  N_MATS  per-lane strobe; bit i qualifies sum_in[i].
- sum_in  input  DATA_WIDTH x [N_MATS-1:0]  unpacked array of per-lane scores.
- in_ready  output  1  high only in COLLECT; lane strobes are accepted only when high.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- class_idx  output  IDX_W  index of the winning lane.
- max_score  output  DATA_WIDTH  score of the winning lane.
- drop_err  output  1  sticky; set when any valid_in bit arrives while in_ready=0.

Behaviour:
- Reset (async assert, all state): state=COLLECT, lane flags=0, score regs=0, out_valid=0, class_idx=0, max_score=0, drop_err=0. in_ready=1 during and after reset.
- States: COLLECT -> SCAN -> DONE -> COLLECT.
- COLLECT:
  - Each edge with valid_in[i]=1 writes sum_in[i] into score[i] and sets flag[i].
  - A repeated strobe on an already-flagged lane overwrites score[i] (last write wins).
  - Once every flag would be set after the current edge (including lanes captured that same edge), state->SCAN and cnt=0.
- SCAN:
  - Lasts N_MATS cycles; cycle k processes lane k.
  - k=0 unconditionally loads best_val=score[0], best_idx=0.
  - For k>0, update only when score[k] > best_val, using a signed, strictly-greater compare. Ties therefore keep the lowest index.
  - On the edge that processes k=N_MATS-1, state->DONE; class_idx and max_score are registered from the final best on that edge.
- DONE:
  - out_valid=1; class_idx and max_score are held stable until the handshake completes.
  - On an edge with out_valid & out_ready: out_valid->0, all flags cleared, state->COLLECT. Score regs are not cleared.
- Latency: final lane captured at edge T -> out_valid high after edge T+N_MATS. Example: N_MATS=10 gives 10 cycles.
- Throughput: one result per N_MATS+2 cycles minimum, i.e. capture edge + N_MATS scan + handshake edge.
- Backpressure:
  - valid_in bits seen while in_ready=0 (SCAN or DONE) are discarded and set drop_err.
  - drop_err is cleared only by rst.
  - A strobe coincident with the DONE->COLLECT handshake edge is also dropped, because in_ready is still 0 in that cycle.
- Reset mid-operation (any state): everything returns immediately to reset values; partially collected lanes are lost and no out_valid pulse follows.
- out_ready while out_valid=0: ignored.

Test Plan:
- All lanes same cycle: N_MATS=10, scores i*16 except lane7=16'h0300 -> out_valid exactly 10 cycles after the capture edge; class_idx=7, max_score=16'h0300.
- Staggered lanes with overwrite: lanes 0-4 at cycle 0, lanes 5-9 at cycle 3; lane2 re-sent at cycle 2 as 16'h7FFF -> class_idx=2, max_score=16'h7FFF. Timing is measured from the cycle-3 capture edge.
- Signed and tie handling:
  - All scores negative, lanes 3 and 8 both 16'hFFF0 (-16), the rest 16'h8000 -> class_idx=3, max_score=16'hFFF0.
  - All-equal scores -> class_idx=0.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE -> outputs stable; in_ready=0 throughout.
  - Strobe valid_in during that window -> drop_err=1 and the next result is unaffected.
  - Then out_ready=1 -> in_ready=1 on the following cycle.
- Reset mid-SCAN: assert rst at SCAN cycle k=4 -> out_valid, class_idx, max_score and drop_err read 0 asynchronously.
  - Re-sending a full lane set afterwards yields the correct result with no stale flags.
